// File: rtl/osd_ram_arbiter_pkg.sv
// osd_pkg: RAM-op state encoding and default OSD RAM widths shared with spi_osd
package osd_pkg;
  localparam int C_ADDR_BITS = 12;
  localparam int C_DATA_BITS = 8;
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2
  } state_t;
endpackage

// File: rtl/osd_ram_arbiter_if.sv
// osd_ram_arbiter_if: pixel read, SPI write, RAM-side and status signals of the OSD RAM arbiter
interface osd_ram_arbiter_if import osd_pkg::*; #(
  parameter int AW = C_ADDR_BITS,
  parameter int DW = C_DATA_BITS,
  parameter int LW = 3
);
  logic          i_video_req;
  logic [AW-1:0] i_video_addr;
  logic [DW-1:0] o_video_data;
  logic          o_video_valid;
  logic          i_wr_valid;
  logic [AW-1:0] i_wr_addr;
  logic [DW-1:0] i_wr_data;
  logic          o_wr_ready;
  logic [AW-1:0] o_ram_addr;
  logic          o_ram_we;
  logic [DW-1:0] o_ram_wdata;
  logic [DW-1:0] i_ram_rdata;
  logic [LW-1:0] o_fifo_level;
  logic          o_starved;
  modport master (
    output i_video_req, i_video_addr, i_wr_valid, i_wr_addr, i_wr_data, i_ram_rdata,
    input  o_video_data, o_video_valid, o_wr_ready, o_ram_addr, o_ram_we, o_ram_wdata,
           o_fifo_level, o_starved
  );
  modport slave (
    input  i_video_req, i_video_addr, i_wr_valid, i_wr_addr, i_wr_data, i_ram_rdata,
    output o_video_data, o_video_valid, o_wr_ready, o_ram_addr, o_ram_we, o_ram_wdata,
           o_fifo_level, o_starved
  );
endinterface

// File: rtl/osd_ram_arbiter_wr_fifo.sv
// osd_wr_fifo: register-based synchronous FIFO queueing SPI writes for the OSD RAM
module osd_wr_fifo #(
  parameter int W = 20,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int LW = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [LW-1:0] level,
  output logic          full,
  output logic          empty
);
  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [LW-1:0] lvl_q, lvl_d;
  logic          pu, po;
  assign full  = lvl_q == LW'(DEPTH);
  assign empty = lvl_q == '0;
  assign level = lvl_q;
  assign dout  = mem_q[rd_q];
  // power-of-2 depth lets the pointers wrap by plain overflow
  always_comb begin
    pu = push & ~full;
    po = pop & ~empty;
    mem_d = mem_q;
    if (pu) mem_d[wr_q] = din;
    wr_d = pu ? wr_q + PW'(1) : wr_q;
    rd_d = po ? rd_q + PW'(1) : rd_q;
    lvl_d = lvl_q + LW'(pu) - LW'(po);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      mem_q <= '{default: '0};
      wr_q <= '0;
      rd_q <= '0;
      lvl_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      lvl_q <= lvl_d;
    end
endmodule

// File: rtl/osd_ram_arbiter.sv
// osd_ram_arbiter: shares the single-port OSD RAM between pixel fetch (absolute priority) and queued SPI writes
module osd_ram_arbiter import osd_pkg::*; #(
  parameter int C_addr_bits = C_ADDR_BITS,
  parameter int C_data_bits = C_DATA_BITS,
  parameter int C_fifo_depth = 4,
  parameter int C_starve_limit = 1023
) (
  input logic clk_pixel,
  input logic reset,
  osd_ram_arbiter_if.slave bus
);
  localparam int LW = $clog2(C_fifo_depth) + 1;
  localparam int SW = $clog2(C_starve_limit + 1);
  localparam int FW = C_addr_bits + C_data_bits;
  state_t                 state_q, state_d;
  logic [C_addr_bits-1:0] addr_q, addr_d;
  logic [C_data_bits-1:0] wdata_q, wdata_d;
  logic                   vld_q, vld_d;
  logic [SW-1:0]          cnt_q, cnt_d;
  logic                   starved_q, starved_d;
  logic                   push, pop, full, empty;
  logic [FW-1:0]          head;
  logic [LW-1:0]          level;
  osd_wr_fifo #(.W(FW), .DEPTH(C_fifo_depth)) u_fifo (
    .clk(clk_pixel),
    .rst(reset),
    .push(push),
    .pop(pop),
    .din({bus.i_wr_addr, bus.i_wr_data}),
    .dout(head),
    .level(level),
    .full(full),
    .empty(empty)
  );
  always_ff @(posedge clk_pixel or posedge reset)
    if (reset) begin
      state_q <= S_IDLE;
      addr_q <= '0;
      wdata_q <= '0;
      vld_q <= 1'b0;
      cnt_q <= '0;
      starved_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      vld_q <= vld_d;
      cnt_q <= cnt_d;
      starved_q <= starved_d;
    end
  always_comb state_d = bus.i_video_req ? S_READ : !empty ? S_WRITE : S_IDLE;
  // the FIFO head pops in the same cycle its write is chosen
  always_comb begin
    push = bus.i_wr_valid & ~full;
    pop = state_d == S_WRITE;
    addr_d = state_d == S_READ ? bus.i_video_addr :
             state_d == S_WRITE ? head[FW-1 -: C_addr_bits] : addr_q;
    wdata_d = state_d == S_WRITE ? head[C_data_bits-1:0] : wdata_q;
    vld_d = state_q == S_READ;
    cnt_d = (empty | pop) ? '0 : cnt_q == SW'(C_starve_limit) ? cnt_q : cnt_q + SW'(1);
    starved_d = starved_q | (cnt_d == SW'(C_starve_limit));
  end
  assign bus.o_ram_addr    = addr_q;
  assign bus.o_ram_we      = state_q == S_WRITE;
  assign bus.o_ram_wdata   = wdata_q;
  assign bus.o_video_valid = vld_q;
  assign bus.o_video_data  = vld_q ? bus.i_ram_rdata : '0;
  assign bus.o_fifo_level  = level;
  assign bus.o_wr_ready    = ~full;
  assign bus.o_starved     = starved_q;
endmodule

// File: doc/osd_ram_arbiter.md
Name: osd_ram_arbiter

Overview:
- Shares one single-port synchronous OSD character/attribute RAM between two requesters:
  - the pixel-side fetch path, which has hard real-time priority;
  - the SPI command writer, which is buffered through a small write FIFO.
- Sits between the SPI slave/command decoder and the OSD RAM, in the clk_pixel domain.
- Feeds the character fetch stage of the overlay that drives vga2dvid.

Parameters:
- C_addr_bits, 12: RAM address width (4096 cells).
- C_data_bits, 8: RAM data width.
- C_fifo_depth, 4: write FIFO entries; must be a power of 2, ≥2.
- C_starve_limit, 1023: consecutive cycles a non-empty FIFO may go unserviced before o_starved sets.

Ports:
- clk_pixel, input, 1: pixel clock; the only clock.
- reset, input, 1: asynchronous, active-high reset.
- i_video_req, input, 1: pixel path requests a read this cycle.
- i_video_addr, input, C_addr_bits: read address.
- o_video_data, output, C_data_bits: read data.
- o_video_valid, output, 1: o_video_data is valid (one cycle after the accepted request).
- i_wr_valid, input, 1: SPI writer offers a write.
- i_wr_addr, input, C_addr_bits: write address.
- i_wr_data, input, C_data_bits: write data.
- o_wr_ready, output, 1: FIFO can accept; a push happens when i_wr_valid & o_wr_ready.
- o_ram_addr, output, C_addr_bits: RAM address.
- o_ram_we, output, 1: RAM write enable.
- o_ram_wdata, output, C_data_bits: RAM write data.
- i_ram_rdata, input, C_data_bits: RAM read data; 1-cycle synchronous latency.
- o_fifo_level, output, clog2(C_fifo_depth)+1: current FIFO occupancy.
- o_starved, output, 1: sticky flag; cleared only by reset.

Behaviour:
- Reset values:
  - All outputs 0, except o_wr_ready = 1.
  - FIFO empty, state S_IDLE, starve counter 0.
  - Reset mid-operation drops all queued writes and any in-flight read; o_video_valid = 0 on the first cycle after release.
- States (registered, describe the RAM op issued this cycle):
  - S_IDLE: no op.
  - S_READ: o_ram_addr = i_video_addr, o_ram_we = 0.
  - S_WRITE: o_ram_addr, o_ram_wdata = FIFO head, o_ram_we = 1.
- Arbitration (combinational select, registered RAM-side outputs):
  - i_video_req = 1 → S_READ, whatever the FIFO state.
  - Else FIFO non-empty → S_WRITE, and the head pops in the same cycle.
  - Else → S_IDLE.
- Read latency:
  - Request at cycle N → RAM address registered at edge N+1.
  - o_video_valid = 1 and o_video_data = i_ram_rdata at cycle N+2, i.e. 2 cycles fixed.
  - Back-to-back requests give back-to-back valid data with no bubbles.
- FIFO rules:
  - o_wr_ready = (level < C_fifo_depth); combinational from the level register only, with no pass-through from pop.
  - A push and a pop in the same cycle leave the level unchanged.
  - Pointers wrap modulo C_fifo_depth.
  - Writes commit to RAM strictly in push order.
- Hazard (accepted and documented): a video read of an address whose write is still queued returns the old RAM contents.
- Starvation monitor:
  - Counter increments each cycle the FIFO is non-empty and no pop occurs.
  - Counter clears on any pop or when the FIFO is empty.
  - o_starved sets when the counter reaches C_starve_limit; the counter saturates there.
- In normal operation, writes drain during blanking, when i_video_req = 0.

Decomposition:
- Shared package osd_pkg holds:
  - state encoding constants S_IDLE = 2'd0, S_READ = 2'd1, S_WRITE = 2'd2;
  - default address and data widths, shared with spi_osd.
- One sub-module: osd_wr_fifo, a parameterised synchronous FIFO.
  - Ports: push, pop, din, dout, level, full, empty.
  - Contains registers only; no RAM inference is required at depth 4.

Test Plan:
- Reads only: i_video_req = 1 for addresses 0x000..0x00F, RAM preloaded with data = addr[7:0]
  → o_video_valid high 2 cycles after each request; data 0x00..0x0F in order with no gaps.
- Writes only: push (0x123, 0xA5) and (0x124, 0x5A) with i_video_req = 0
  → o_ram_we pulses on 2 consecutive cycles with those pairs in push order; o_fifo_level ends at 0.
- Contention: i_video_req held at 1 while 4 writes are pushed
  → no o_ram_we; o_fifo_level = 4 and o_wr_ready = 0.
  - Then drop i_video_req → 4 writes drain on 4 consecutive cycles; o_wr_ready returns to 1 after the first pop.
- Simultaneous push and pop at level 2 → level stays 2; data order is preserved across pointer wrap after 10 total pushes.
- Starvation: C_starve_limit = 8, FIFO non-empty, i_video_req held 1
  → o_starved rises exactly 8 cycles after the first blocked cycle and stays high after the FIFO drains.
- Reset asserted asynchronously between edges while level = 3 and a read is in flight
  → outputs clear immediately: level 0, o_video_valid 0, o_ram_we 0.
  - After release, no stale write is ever issued.
